// File: rtl/time_tmr_rr_arbiter.sv
// time_tmr_rr_arbiter
//   Round-robin arbiter feeding one time-redundant (time-TMR) pipeline.
//   Grants are presented with zero latency while IDLE; a stalled grant is
//   locked until the downstream accepts it.  Accepted requester indices are
//   queued in order so the completion side can report which requester owns
//   the oldest outstanding transaction.  Grants stop while MaxOutstanding
//   transactions are in flight.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   req_valid_i  per-requester valid
//   req_data_i   per-requester payload
//   req_ready_o  per-requester accept (only the granted bit can be set)
//   data_o       payload of the presented requester
//   idx_o        index of the presented requester (0 when valid_o=0)
//   valid_o      downstream valid
//   ready_i      downstream ready
//   done_i       one pulse per in-order completion at the TMR end stage
//   done_idx_o   requester index of the oldest outstanding transaction
//   busy_o       at least one transaction outstanding
//   full_o       MaxOutstanding transactions outstanding
module time_tmr_rr_arbiter #(
  parameter int  NumReq         = 4,
  parameter type DataType       = logic,
  parameter int  MaxOutstanding = 4,
  localparam int IdxW           = ($clog2(NumReq) > 1) ? $clog2(NumReq) : 1,
  localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumReq-1:0]   req_valid_i,
  input  DataType             req_data_i [NumReq],
  output logic [NumReq-1:0]   req_ready_o,
  output DataType             data_o,
  output logic [IdxW-1:0]     idx_o,
  output logic                valid_o,
  input  logic                ready_i,
  input  logic                done_i,
  output logic [IdxW-1:0]     done_idx_o,
  output logic                busy_o,
  output logic                full_o
);

  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e          state_q;
  logic [IdxW-1:0] lock_idx_q;
  logic [IdxW-1:0] rr_q;
  logic [CntW-1:0] cnt_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];

  logic            arb_found;
  logic [IdxW-1:0] arb_idx;
  logic [IdxW-1:0] cand;
  logic [IdxW-1:0] grant_idx;
  logic [IdxW-1:0] next_rr;
  logic            has_room;
  logic            push;
  logic            pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Search starts at rr_q and wraps, so the first hit is the round-robin winner.
  // NOTE: every variable driven here gets a default before the loop, otherwise
  // paths that skip an assignment would infer a latch.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = IdxW'((int'(rr_q) + i) % NumReq);
      if (!arb_found && req_valid_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // While LOCKED the stored index is presented regardless of the arbiter, and
  // the requester is assumed to keep its valid high until accepted.
  assign grant_idx = (state_q == LOCKED) ? lock_idx_q : arb_idx;
  assign has_room  = (cnt_q < CntW'(MaxOutstanding));
  assign valid_o   = !rst_i && ((state_q == LOCKED) || (arb_found && has_room));
  assign idx_o     = valid_o ? grant_idx : '0;
  assign data_o    = req_data_i[grant_idx];

  assign push    = valid_o && ready_i;
  assign pop     = done_i && busy_o;
  assign next_rr = (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + IdxW'(1);

  always_comb begin
    req_ready_o = '0;
    if (push) req_ready_o[grant_idx] = 1'b1;
  end

  assign busy_o     = !rst_i && (cnt_q != '0);
  assign full_o     = !rst_i && (cnt_q == CntW'(MaxOutstanding));
  assign done_idx_o = busy_o ? fifo_q[rd_ptr_q] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_o && !ready_i) begin
            state_q    <= LOCKED;
            lock_idx_q <= arb_idx;
          end
        end
        LOCKED: begin
          if (ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (push) rr_q <= next_rr;

      // Push and pop together leave the count unchanged.
      if (push && !pop)      cnt_q <= cnt_q + CntW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CntW'(1);

      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // NOTE: the index storage has no reset; entries are only observed when the
  // count says they were written, so clearing them would add reset fanout only.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= grant_idx;
  end

endmodule

// File: doc/time_tmr_rr_arbiter.md
TIME_TMR_RR_ARBITER -- requirements
Module: time_tmr_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NumReq, default 4: number of requesters sharing one time-redundant pipeline entry (>=2).
REQ-002 The block SHALL have parameter DataType, default logic: payload type passed to the downstream time-TMR start stage.
REQ-003 The block SHALL have parameter MaxOutstanding, default 4: maximum transactions in flight between grant and done (>=1).
REQ-004 The block SHALL define IdxW = max(1, clog2(NumReq)) and CntW = clog2(MaxOutstanding+1).
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port req_valid_i, input, NumReq bits: per-requester valid.
REQ-008 The block SHALL have port req_data_i, input, NumReq x DataType: per-requester payload.
REQ-009 The block SHALL have port req_ready_o, output, NumReq bits: per-requester accept.
REQ-010 The block SHALL have port data_o, output, DataType: payload to the downstream start stage.
REQ-011 The block SHALL have port idx_o, output, IdxW: index of the requester currently presented.
REQ-012 The block SHALL have port valid_o, output, 1 bit, and port ready_i, input, 1 bit: downstream handshake.
REQ-013 The block SHALL have port done_i, input, 1 bit: one pulse per in-order completion at the TMR end stage.
REQ-014 The block SHALL have port done_idx_o, output, IdxW: requester index of the oldest outstanding transaction.
REQ-015 The block SHALL have ports busy_o and full_o, outputs, 1 bit each: outstanding count !=0 and ==MaxOutstanding.

Function
REQ-016 The arbiter SHALL use two states, IDLE and LOCKED.
REQ-017 In IDLE with cnt<MaxOutstanding and any req_valid_i set, it SHALL select the first set index at or after rr_q, wrapping modulo NumReq, and drive valid_o=1 with data_o/idx_o of that requester in the same cycle (zero latency).
REQ-018 In IDLE with no valid request or cnt==MaxOutstanding, it SHALL drive valid_o=0.
REQ-019 When valid_o=1 and ready_i=0, it SHALL transition IDLE->LOCKED and store the granted index.
REQ-020 In LOCKED it SHALL present only the stored requester, with no re-arbitration, and it SHALL return to IDLE on ready_i=1.
REQ-021 Requesters SHALL hold valid and data stable until accepted; behaviour is undefined otherwise.
REQ-022 req_ready_o[g] SHALL equal valid_o & ready_i for the granted g; all other bits SHALL be 0.
REQ-023 On accept (valid_o & ready_i) of index g, rr_q SHALL become (g+1) mod NumReq; otherwise rr_q SHALL be unchanged.
REQ-024 cnt SHALL increment on accept alone, decrement on done_i alone, and stay unchanged on both in the same cycle.
REQ-025 done_i with cnt==0 SHALL be ignored, with no underflow.
REQ-026 An index FIFO of depth MaxOutstanding SHALL push g on accept and pop on done_i (if cnt!=0).
REQ-027 done_idx_o SHALL show the FIFO head, or 0 when empty.
REQ-028 Simultaneous push and pop SHALL be legal at any occupancy below full; no push SHALL occur when full (see REQ-018).
REQ-029 The LOCKED state SHALL NOT block done_i processing; the capacity check applies only at grant time in IDLE.

Reset
REQ-030 rst_i=1 at a clock edge SHALL force state=IDLE, rr_q=0, cnt=0, FIFO pointers=0.
REQ-031 During and after reset, valid_o=0, req_ready_o=0, busy_o=0, full_o=0, done_idx_o=0, idx_o=0; data_o is don't-care while valid_o=0.
REQ-032 Reset asserted while LOCKED SHALL drop the pending transaction without a handshake.

Verification (NumReq=4, MaxOutstanding=2)
REQ-033 The bench SHALL cover: all four requesters valid, ready_i=1 continuously -> accepts in order 0,1,2,3,0; rr_q=1,2,3,0,1.
REQ-034 The bench SHALL cover: req 2 valid, ready_i=0 for 3 cycles, req 0 raised in cycle 2 -> idx_o stays 2, LOCKED; on ready_i=1 req_ready_o=4'b0100, then next grant is 0.
REQ-035 The bench SHALL cover: two accepts (idx 1, 3), no done_i -> full_o=1, valid_o=0 despite req_valid_i=4'b1111; done_i -> done_idx_o was 1, becomes 3, grant resumes.
REQ-036 The bench SHALL cover: cnt=1, accept and done_i in the same cycle -> cnt stays 1, done_idx_o updates to the newly pushed index.
REQ-037 The bench SHALL cover: done_i with cnt=0 -> cnt stays 0, busy_o=0, done_idx_o=0.
REQ-038 The bench SHALL cover: rst_i pulsed while LOCKED with cnt=1 -> next cycle valid_o=0, cnt=0, rr_q=0, all req_ready_o=0.
